// File: rtl/uart_rx.sv
// UART receiver: start bit, 8 data bits MSB-first, even parity, one stop bit.
// Delivers bytes with a valid/ack handshake plus parity, framing and overrun status.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    logic [1:0]    sync_r;
    logic          rx_s;
    state_t        state_r, state_next_s;
    logic [CW-1:0] cnt_r, cnt_next_s;
    logic [3:0]    bit_r, bit_next_s;
    logic [7:0]    shift_r, shift_next_s;
    logic          par_bad_r, par_bad_next_s;
    logic          load_s, stop_s, busy_next_s;
    logic [7:0]    rx_data_r;
    logic          rx_valid_r, parity_err_r, frame_err_r, overrun_r, busy_r;

    assign rx_s = sync_r[1];

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx_in};
        end
    end

    // Frame sequencing: next state, bit-timing counters, shift register
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r + CNT_ONE;
        bit_next_s     = bit_r;
        shift_next_s   = shift_r;
        par_bad_next_s = par_bad_r;
        load_s         = 1'b0;
        stop_s         = 1'b1;
        case (state_r)
            IDLE: begin
                cnt_next_s = {CW{1'b0}};
                bit_next_s = 4'd0;
                if (!rx_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_next_s = {CW{1'b0}};
                    // A line already back high at mid start bit is a glitch
                    if (!rx_s) begin
                        state_next_s = DATA;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_next_s   = {CW{1'b0}};
                    shift_next_s = {shift_r[6:0], rx_s};
                    if (bit_r == 4'd7) begin
                        bit_next_s   = 4'd0;
                        state_next_s = PARITY;
                    end else begin
                        bit_next_s = bit_r + 4'd1;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_next_s     = {CW{1'b0}};
                    par_bad_next_s = even_parity(shift_r) ^ rx_s;
                    state_next_s   = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
            STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_next_s = {CW{1'b0}};
                    load_s     = 1'b1;
                    stop_s     = rx_s;
                    // A low stop bit may be a break; wait for idle before hunting
                    if (rx_s) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = WAIT_HIGH;
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            WAIT_HIGH: begin
                cnt_next_s = {CW{1'b0}};
                if (rx_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_HIGH;
                end
            end
            default: begin
                cnt_next_s   = {CW{1'b0}};
                state_next_s = IDLE;
            end
        endcase
        busy_next_s = (state_next_s == START) || (state_next_s == DATA) ||
                      (state_next_s == PARITY) || (state_next_s == STOP);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            bit_r     <= 4'd0;
            shift_r   <= 8'h00;
            par_bad_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            bit_r     <= bit_next_s;
            shift_r   <= shift_next_s;
            par_bad_r <= par_bad_next_s;
        end
    end

    // Consumer-facing byte, status flags and handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_r    <= 8'h00;
            rx_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            if (load_s) begin
                rx_data_r    <= shift_r;
                parity_err_r <= par_bad_r;
                frame_err_r  <= ~stop_s;
                rx_valid_r   <= 1'b1;
                overrun_r    <= rx_valid_r & ~rx_ack;
            end else if (rx_valid_r && rx_ack) begin
                rx_valid_r <= 1'b0;
                overrun_r  <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
                overrun_r  <= overrun_r;
            end
        end
    end

    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

endmodule
